// File: rtl/i2c_pkg.sv
// Shared definitions for the MPU9250 init sequencer: FSM states, ROM entry layout,
// device address and register map.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_BUSY,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } init_state_t;

  // 24-bit ROM entry: {reg[23:16], data[15:8], delay[7:0]}
  localparam int ENTRY_W         = 24;
  localparam int ENTRY_REG_LSB   = 16;
  localparam int ENTRY_DATA_LSB  = 8;
  localparam int ENTRY_DELAY_LSB = 0;

  localparam logic [6:0] MPU9250_ADDR = 7'h68;

  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] CONFIG       = 8'h1A;
  localparam logic [7:0] GYRO_CONFIG  = 8'h1B;
  localparam logic [7:0] ACCEL_CONFIG = 8'h1C;

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Request/response signals between the init sequencer and the single-register write engine.
interface i2c_init_sequencer_if;
  logic       i2c_start;
  logic [6:0] i2c_device_address;
  logic [7:0] i2c_register_address;
  logic [7:0] i2c_data;
  logic       engine_done;

  modport master (
    output i2c_start, i2c_device_address, i2c_register_address, i2c_data,
    input  engine_done
  );

  modport slave (
    input  i2c_start, i2c_device_address, i2c_register_address, i2c_data,
    output engine_done
  );
endinterface

// File: rtl/i2c_init_sequencer_rom.sv
// Fixed MPU9250 power-up write table, index -> {reg, data, delay}.
module i2c_init_rom
  import i2c_pkg::*;
(
  input  logic [7:0]         index,
  output logic [ENTRY_W-1:0] entry
);
  always_comb begin
    entry = '0;
    case (index)
      8'd0: entry = {PWR_MGMT_1,   8'h80, 8'd100};  // device reset, 100 ms settle
      8'd1: entry = {PWR_MGMT_1,   8'h01, 8'd10};
      8'd2: entry = {CONFIG,       8'h03, 8'd0};
      8'd3: entry = {ACCEL_CONFIG, 8'h08, 8'd0};
      default: entry = '0;
    endcase
  end
endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init ROM, issuing one engine write per entry with a post-write gap;
// flags init_done when the table is exhausted or error on an engine handshake timeout.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int         NUM_WRITES        = 4,
  parameter logic [6:0] DEVICE_ADDR       = MPU9250_ADDR,
  parameter int         DELAY_UNIT_CYCLES = 25000,
  parameter int         MIN_GAP_CYCLES    = 16,
  parameter int         TIMEOUT_CYCLES    = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  i2c_init_sequencer_if.master bus,
  output logic                busy,
  output logic                init_done,
  output logic                error,
  output logic [7:0]          index
);
  localparam int MAX_DLY = 255 * DELAY_UNIT_CYCLES;
  localparam int TMAX    = (MAX_DLY > TIMEOUT_CYCLES) ? MAX_DLY : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_WRITES - 1);

  init_state_t     state, state_n;
  logic [1:0]      done_sync;
  logic            done_s;
  logic [TW-1:0]   timer, timer_n;
  logic [7:0]      reg_q, data_q, delay_q;
  logic [ENTRY_W-1:0] rom_entry;
  logic [31:0]     gap_full;
  logic [TW-1:0]   gap_cycles;

  i2c_init_rom u_rom (.index(index), .entry(rom_entry));

  assign done_s     = done_sync[1];
  assign gap_full   = 32'(delay_q) * 32'(DELAY_UNIT_CYCLES);
  assign gap_cycles = (gap_full < 32'(MIN_GAP_CYCLES)) ? TW'(MIN_GAP_CYCLES) : TW'(gap_full);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      done_sync <= 2'b11;
      timer     <= '0;
      index     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      delay_q   <= '0;
      init_done <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      done_sync <= {done_sync[0], bus.engine_done};
      timer     <= timer_n;
      if (state == ST_IDLE && go) begin
        index     <= '0;
        init_done <= 1'b0;
        error     <= 1'b0;
      end
      if (state == ST_LOAD) begin
        reg_q   <= rom_entry[ENTRY_REG_LSB   +: 8];
        data_q  <= rom_entry[ENTRY_DATA_LSB  +: 8];
        delay_q <= rom_entry[ENTRY_DELAY_LSB +: 8];
      end
      if (state == ST_GAP && state_n == ST_LOAD) index <= index + 8'd1;
      if (state_n == ST_DONE)  init_done <= 1'b1;
      if (state_n == ST_ERROR) error     <= 1'b1;
    end
  end

  // Timeouts fire TIMEOUT_CYCLES after entering REQ/BUSY; GAP lasts exactly gap_cycles.
  always_comb begin
    state_n = state;
    timer_n = timer;
    case (state)
      ST_IDLE: if (go) state_n = ST_LOAD;
      ST_LOAD: begin
        timer_n = '0;
        state_n = ST_REQ;
      end
      ST_REQ: begin
        if (!done_s) begin
          state_n = ST_BUSY;
          timer_n = '0;
        end else if (timer == TO_LAST) state_n = ST_ERROR;
        else timer_n = timer + TW'(1);
      end
      ST_BUSY: begin
        if (done_s) begin
          state_n = ST_GAP;
          timer_n = gap_cycles - TW'(1);
        end else if (timer == TO_LAST) state_n = ST_ERROR;
        else timer_n = timer + TW'(1);
      end
      ST_GAP: begin
        if (timer == '0) state_n = (index == IDX_LAST) ? ST_DONE : ST_LOAD;
        else timer_n = timer - TW'(1);
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_ERROR: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign busy                     = (state == ST_LOAD) || (state == ST_REQ) ||
                                    (state == ST_BUSY) || (state == ST_GAP);
  assign bus.i2c_start            = (state == ST_REQ);
  assign bus.i2c_device_address   = DEVICE_ADDR;
  assign bus.i2c_register_address = reg_q;
  assign bus.i2c_data             = data_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a behavioural write engine driven inline.
module tb_i2c_init_sequencer;
  localparam int DU  = 10;    // shortened delay unit keeps the 100-unit gap simulable
  localparam int TO  = 4096;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       go    = 1'b0;
  logic       busy, init_done, error;
  logic [7:0] index;
  int         n_vec  = 0;
  int         n_miss = 0;

  i2c_init_sequencer_if bus();

  i2c_init_sequencer #(
    .NUM_WRITES(4), .DEVICE_ADDR(7'h68), .DELAY_UNIT_CYCLES(DU),
    .MIN_GAP_CYCLES(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .bus(bus.master),
    .busy(busy), .init_done(init_done), .error(error), .index(index)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int cnt = 0;
    while (!bus.i2c_start && cnt < 5000) begin
      @(negedge clock);
      cnt++;
    end
    if (!bus.i2c_start) chk({tag, " start timeout"}, 0, 1);
  endtask

  // Engine model: called with i2c_start high; drops done, holds it low 40 cycles,
  // raises it and measures cycles until the next start (or init_done).
  task automatic engine_xact(input string tag, input logic [7:0] er, input logic [7:0] ed,
                             input logic [7:0] ei, input int exp_gap, input bit poke_go);
    int cnt;
    chk({tag, " reg"},   bus.i2c_register_address, er);
    chk({tag, " data"},  bus.i2c_data, ed);
    chk({tag, " index"}, index, ei);
    repeat (3) @(negedge clock);
    bus.engine_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      go = poke_go && (i == 20);
      if (i == 20) chk({tag, " start dropped"}, bus.i2c_start, 0);
    end
    go = 1'b0;
    if (poke_go) chk({tag, " index after go"}, index, ei);
    bus.engine_done = 1'b1;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!bus.i2c_start && !init_done && cnt < 5000);
    chk({tag, " gap"}, cnt, exp_gap);
  endtask

  initial begin
    int cnt;
    bus.engine_done = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst start", bus.i2c_start, 0);
    chk("rst busy", busy, 0);
    chk("rst init_done", init_done, 0);
    chk("rst error", error, 0);
    chk("rst index", index, 0);
    chk("rst reg", bus.i2c_register_address, 0);
    chk("rst data", bus.i2c_data, 0);
    chk("dev addr", bus.i2c_device_address, 7'h68);
    reset = 1'b0;
    @(negedge clock);

    // go -> LOAD -> REQ, start visible two edges after go sampled
    pulse_go();
    chk("load start", bus.i2c_start, 0);
    chk("load busy", busy, 1);
    @(negedge clock);
    chk("req start", bus.i2c_start, 1);
    // gaps: done rise -> start = 3 sync/fsm + gap + LOAD + REQ edge
    engine_xact("e0", 8'h6B, 8'h80, 8'd0, 100 * DU + 4, 1'b0);
    engine_xact("e1", 8'h6B, 8'h01, 8'd1, 10 * DU + 4, 1'b1);
    engine_xact("e2", 8'h1A, 8'h03, 8'd2, 16 + 4, 1'b0);
    engine_xact("e3", 8'h1C, 8'h08, 8'd3, 16 + 3, 1'b0);
    chk("fin init_done", init_done, 1);
    @(negedge clock);
    chk("fin busy", busy, 0);
    chk("fin error", error, 0);
    chk("fin init_done sticky", init_done, 1);

    // rerun clears init_done, then reset during BUSY of entry 2
    pulse_go();
    chk("rerun init_done", init_done, 0);
    chk("rerun index", index, 0);
    @(negedge clock);
    engine_xact("r0", 8'h6B, 8'h80, 8'd0, 100 * DU + 4, 1'b0);
    engine_xact("r1", 8'h6B, 8'h01, 8'd1, 10 * DU + 4, 1'b0);
    chk("r2 index", index, 2);
    repeat (3) @(negedge clock);
    bus.engine_done = 1'b0;
    repeat (10) @(negedge clock);
    chk("r2 in busy", bus.i2c_start, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("mid rst start", bus.i2c_start, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst index", index, 0);
    chk("mid rst init_done", init_done, 0);
    reset = 1'b0;
    bus.engine_done = 1'b1;
    repeat (3) @(negedge clock);

    // engine never responds -> timeout
    pulse_go();
    wait_start("to");
    cnt = 0;
    while (!error && cnt < TO + 100) begin
      @(negedge clock);
      cnt++;
    end
    chk("timeout cycles", cnt, TO);
    chk("timeout start", bus.i2c_start, 0);
    chk("timeout index", index, 0);
    @(negedge clock);
    chk("timeout busy", busy, 0);
    chk("timeout error sticky", error, 1);
    chk("timeout init_done", init_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
